tag_channel_filter: RTL

Stream stage placed directly upstream of the tag-interval monitor (user_sample). It drops tags whose channel is not enabled in a 64-bit channel mask by clearing the corresponding tkeep bits. Words left with no valid lane are removed from the stream entirely. The block keeps saturating pass/drop tag counters and runs at full throughput under arbitrary downstream backpressure, using a registered output and a skid buffer.

---
 rtl/tag_stream_pkg.sv | 21 ++
 rtl/tag_channel_filter_if.sv | 17 +
 rtl/axis_skid_buffer.sv | 54 +++++
 rtl/tag_channel_filter.sv | 77 +++++++
 4 files changed

// File: rtl/tag_stream_pkg.sv
// Shared constants and helpers for tag streams: lane field widths, channel-code
// layout and a popcount used by the pass/drop counters.
package tag_stream_pkg;

    localparam int CHANNEL_WIDTH     = 6;
    localparam int TAGTIME_WIDTH     = 64;
    localparam int CHANNEL_EDGE_BIT  = 5;
    localparam int NUM_CHANNEL_CODES = 64;
    localparam int POPCOUNT_WIDTH    = 7;

    // Wide enough for any lane count up to one bit per channel code.
    function automatic logic [POPCOUNT_WIDTH-1:0] popcount(input logic [NUM_CHANNEL_CODES-1:0] bits);
        logic [POPCOUNT_WIDTH-1:0] count;
        count = '0;
        for (int i = 0; i < NUM_CHANNEL_CODES; i++) begin
            count = count + POPCOUNT_WIDTH'(bits[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/tag_channel_filter_if.sv
// AXI-Stream style tag beat: per-lane keep, 64-bit tag time and 6-bit channel code.
interface tag_channel_filter_if
    import tag_stream_pkg::*;
#(
    parameter int WORD_WIDTH = 4
) ();

    logic                                      tvalid;
    logic                                      tready;
    logic [WORD_WIDTH-1:0]                     tkeep;
    logic [WORD_WIDTH-1:0][TAGTIME_WIDTH-1:0]  tagtime;
    logic [WORD_WIDTH-1:0][CHANNEL_WIDTH-1:0]  channel;

    modport master (output tvalid, tkeep, tagtime, channel, input tready);
    modport slave  (input tvalid, tkeep, tagtime, channel, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Registered output stage with one skid entry: full throughput under arbitrary
// backpressure while both ready and valid come straight from flops.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             drain;

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = out_ready || !out_valid;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: skid payload is qualified by skid_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!drain && accept) begin
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/tag_channel_filter.sv
// Drops tags whose channel is not enabled in channel_mask, removes beats left
// empty, and keeps saturating passed/dropped tag counters.
module tag_channel_filter
    import tag_stream_pkg::*;
#(
    parameter int WORD_WIDTH    = 4,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CHANNEL_CODES-1:0] channel_mask,
    input  logic                         clear_counters,
    tag_channel_filter_if.slave          s,
    tag_channel_filter_if.master         m,
    output logic [COUNTER_WIDTH-1:0]     passed_count,
    output logic [COUNTER_WIDTH-1:0]     dropped_count
);

    localparam int PAYLOAD_WIDTH = WORD_WIDTH * (1 + TAGTIME_WIDTH + CHANNEL_WIDTH);

    logic [WORD_WIDTH-1:0]    keep_f;
    logic [WORD_WIDTH-1:0]    keep_drop;
    logic                     accept;
    logic [PAYLOAD_WIDTH-1:0] in_payload;
    logic [PAYLOAD_WIDTH-1:0] out_payload;

    function automatic logic [COUNTER_WIDTH-1:0] sat_add(
        input logic [COUNTER_WIDTH-1:0]  count,
        input logic [POPCOUNT_WIDTH-1:0] inc
    );
        logic [COUNTER_WIDTH:0] sum;
        sum = {1'b0, count} + (COUNTER_WIDTH+1)'(inc);
        return sum[COUNTER_WIDTH] ? '1 : sum[COUNTER_WIDTH-1:0];
    endfunction

    // NOTE: default first so every path assigns keep_f and no latch is inferred.
    always_comb begin
        keep_f = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            keep_f[i] = s.tkeep[i] && channel_mask[s.channel[i]];
        end
    end

    assign keep_drop  = s.tkeep & ~keep_f;
    assign accept     = s.tvalid && s.tready;
    assign in_payload = {keep_f, s.tagtime, s.channel};

    // Empty beats are still accepted upstream but never offered to the buffer.
    axis_skid_buffer #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s.tvalid && (|keep_f)),
        .in_ready  (s.tready),
        .in_data   (in_payload),
        .out_valid (m.tvalid),
        .out_ready (m.tready),
        .out_data  (out_payload)
    );

    assign {m.tkeep, m.tagtime, m.channel} = out_payload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            passed_count  <= '0;
            dropped_count <= '0;
        end else if (clear_counters) begin
            passed_count  <= '0;
            dropped_count <= '0;
        end else if (accept) begin
            passed_count  <= sat_add(passed_count,  popcount(NUM_CHANNEL_CODES'(keep_f)));
            dropped_count <= sat_add(dropped_count, popcount(NUM_CHANNEL_CODES'(keep_drop)));
        end
    end

endmodule
